// File: rtl/dense_result_collector.sv
// -----------------------------------------------------------------------------
// dense_result_collector
// Captures the 2N-1 diagonal result lanes of the dense systolic multiplier into
// an N x N register matrix. Once every element has arrived, it drains the
// matrix in row-major order over a valid/ready stream.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   s_in_bus[L]     lane L data; lane L carries diagonal d = L-(N-1) = col-row
//   valid_bit_s_in  per-lane element valid
//   m_data/m_row/m_col/m_valid/m_ready/m_last
//                   row-major drain stream; m_last marks C[N-1][N-1]
//   busy            a capture is in progress or the drain is not yet complete
//   err_overflow    sticky; an input element was discarded
// -----------------------------------------------------------------------------
module dense_result_collector #(
    parameter int unsigned N            = 3,
    parameter int unsigned OUTPUT_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OUTPUT_WIDTH-1:0] s_in_bus       [2*N-2:0],
    input  logic                    valid_bit_s_in [2*N-2:0],
    output logic [OUTPUT_WIDTH-1:0] m_data,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] m_row,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] m_col,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic                    busy,
    output logic                    err_overflow
);

    localparam int unsigned NL    = 2 * N - 1;
    localparam int unsigned CW    = $clog2(N + 1);
    localparam int unsigned TW    = $clog2(N * N + 1);
    localparam int unsigned IW    = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned TOTAL = N * N;

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_DRAIN   = 1'b1
    } state_t;

    // Diagonal offset (col - row) carried by a lane.
    function automatic int lane_diag(input int lane);
        return lane - (int'(N) - 1);
    endfunction

    // Number of elements on a lane's diagonal.
    function automatic int lane_len(input int lane);
        int d;
        d = lane_diag(lane);
        return int'(N) - ((d < 0) ? -d : d);
    endfunction

    // Row of the first element on a lane's diagonal.
    function automatic int lane_r0(input int lane);
        int d;
        d = lane_diag(lane);
        return (d < 0) ? -d : 0;
    endfunction

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q [NL];
    logic [CW-1:0]           cnt_d [NL];
    logic [TW-1:0]           total_q, total_d;
    logic [OUTPUT_WIDTH-1:0] m_data_q, m_data_d;
    logic [IW-1:0]           m_row_q, m_row_d;
    logic [IW-1:0]           m_col_q, m_col_d;
    logic                    m_valid_q, m_valid_d;
    logic                    m_last_q, m_last_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;

    logic [OUTPUT_WIDTH-1:0] mat_q [N][N];

    logic                    wr_en  [NL];
    logic [IW-1:0]           wr_row [NL];
    logic [IW-1:0]           wr_col [NL];

    logic [IW-1:0]           nxt_row_c, nxt_col_c;

    // Row-major successor of the element currently presented.
    always_comb begin
        nxt_row_c = m_row_q;
        nxt_col_c = m_col_q + IW'(1);
        if (m_col_q == IW'(N - 1)) begin
            nxt_row_c = m_row_q + IW'(1);
            nxt_col_c = '0;
        end
    end

    // Capture, drain sequencing and discard detection.
    always_comb begin
        int tot;
        state_d   = state_q;
        cnt_d     = cnt_q;
        total_d   = total_q;
        m_data_d  = m_data_q;
        m_row_d   = m_row_q;
        m_col_d   = m_col_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        err_d     = err_q;
        tot       = int'(total_q);
        for (int l = 0; l < int'(NL); l++) begin
            wr_en[l]  = 1'b0;
            wr_row[l] = '0;
            wr_col[l] = '0;
        end

        case (state_q)
            S_COLLECT: begin
                for (int l = 0; l < int'(NL); l++) begin
                    if (valid_bit_s_in[l]) begin
                        if (int'(cnt_q[l]) < lane_len(l)) begin
                            wr_en[l]  = 1'b1;
                            wr_row[l] = IW'(lane_r0(l) + int'(cnt_q[l]));
                            wr_col[l] = IW'(lane_r0(l) + int'(cnt_q[l]) + lane_diag(l));
                            cnt_d[l]  = cnt_q[l] + CW'(1);
                            tot       = tot + 1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                total_d = TW'(tot);
                if (tot == int'(TOTAL)) begin
                    state_d = S_DRAIN;
                end
            end

            S_DRAIN: begin
                // The wavefront cannot stall, so anything arriving now is lost.
                for (int l = 0; l < int'(NL); l++) begin
                    if (valid_bit_s_in[l]) begin
                        err_d = 1'b1;
                    end
                end
                if (!m_valid_q) begin
                    // First drain cycle: present C[0][0].
                    m_valid_d = 1'b1;
                    m_row_d   = '0;
                    m_col_d   = '0;
                    m_data_d  = mat_q[0][0];
                    m_last_d  = (TOTAL == 1);
                end else if (m_ready) begin
                    if (m_last_q) begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        m_row_d   = '0;
                        m_col_d   = '0;
                        total_d   = '0;
                        state_d   = S_COLLECT;
                        for (int l = 0; l < int'(NL); l++) begin
                            cnt_d[l] = '0;
                        end
                    end else begin
                        m_row_d  = nxt_row_c;
                        m_col_d  = nxt_col_c;
                        m_data_d = mat_q[nxt_row_c][nxt_col_c];
                        m_last_d = (nxt_row_c == IW'(N - 1)) && (nxt_col_c == IW'(N - 1));
                    end
                end
            end

            default: begin
                state_d = S_COLLECT;
            end
        endcase

        busy_d = (total_d != '0) || (state_d == S_DRAIN);
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_COLLECT;
            total_q   <= '0;
            m_data_q  <= '0;
            m_row_q   <= '0;
            m_col_q   <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            for (int l = 0; l < int'(NL); l++) begin
                cnt_q[l] <= '0;
            end
        end else begin
            state_q   <= state_d;
            total_q   <= total_d;
            m_data_q  <= m_data_d;
            m_row_q   <= m_row_d;
            m_col_q   <= m_col_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            for (int l = 0; l < int'(NL); l++) begin
                cnt_q[l] <= cnt_d[l];
            end
        end
    end

    // Matrix storage; lanes target disjoint slots so all writes may coincide.
    always_ff @(posedge clk) begin
        for (int l = 0; l < int'(NL); l++) begin
            if (wr_en[l]) begin
                mat_q[wr_row[l]][wr_col[l]] <= s_in_bus[l];
            end
        end
    end

    assign m_data       = m_data_q;
    assign m_row        = m_row_q;
    assign m_col        = m_col_q;
    assign m_valid      = m_valid_q;
    assign m_last       = m_last_q;
    assign busy         = busy_q;
    assign err_overflow = err_q;

endmodule

// File: tb/tb_dense_result_collector.sv
// -----------------------------------------------------------------------------
// tb_dense_result_collector
// Directed bench for dense_result_collector with N=3, OUTPUT_WIDTH=32.
// Product matrix is A*I = [[1,2,3],[4,5,6],[7,8,9]].
// -----------------------------------------------------------------------------
module tb_dense_result_collector;

    localparam int N  = 3;
    localparam int W  = 32;
    localparam int NL = 2 * N - 1;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  s_in_bus       [2*N-2:0];
    logic          valid_bit_s_in [2*N-2:0];
    logic [W-1:0]  m_data;
    logic [1:0]    m_row;
    logic [1:0]    m_col;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;
    logic          err_overflow;

    int n_checks;
    int n_pass;
    int n_fail;
    int exp_m [N][N];

    dense_result_collector #(.N(N), .OUTPUT_WIDTH(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_in_bus       (s_in_bus),
        .valid_bit_s_in (valid_bit_s_in),
        .m_data         (m_data),
        .m_row          (m_row),
        .m_col          (m_col),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_last         (m_last),
        .busy           (busy),
        .err_overflow   (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        for (int l = 0; l < NL; l++) begin
            valid_bit_s_in[l] = 1'b0;
            s_in_bus[l]       = '0;
        end
    endtask

    // Drive cycle t of a delivery. Systolic timing: element k of a lane with
    // |d| arrives at t = |d| + 2k. Simultaneous: element k arrives at t = k.
    task automatic set_lanes(input int t, input bit simul);
        int d, ad, r0, len, k;
        clear_lanes();
        for (int l = 0; l < NL; l++) begin
            d   = l - (N - 1);
            ad  = (d < 0) ? -d : d;
            r0  = (d < 0) ? -d : 0;
            len = N - ad;
            k   = -1;
            if (simul) k = t;
            else if (t >= ad && ((t - ad) % 2) == 0) k = (t - ad) / 2;
            if (k >= 0 && k < len) begin
                valid_bit_s_in[l] = 1'b1;
                s_in_bus[l]       = W'(exp_m[r0 + k][r0 + k + d]);
            end
        end
    endtask

    // Deliver a full matrix; optionally add a surplus lane0 pulse at cycle extra_t.
    task automatic send(input bit simul, input int extra_t);
        int ncyc;
        ncyc = simul ? N : 2 * N - 1;
        for (int t = 0; t < ncyc; t++) begin
            set_lanes(t, simul);
            if (t == extra_t) begin
                valid_bit_s_in[0] = 1'b1;
                s_in_bus[0]       = 32'd99;
            end
            tick();
            if (t == 0) chk("busy_after_first", busy, 1);
            if (t == extra_t) chk("err_after_surplus", err_overflow, 1);
            if (t == ncyc - 1) chk("no_valid_at_capture", m_valid, 0);
        end
        clear_lanes();
        tick();
        chk("valid_rise", m_valid, 1);
    endtask

    // Consume the drain stream and check order, stability and termination.
    task automatic drain(input int mode, input int inject, input bit chk_b2b);
        int idx;
        int cyc;
        bit prev_stall;
        logic [W-1:0] prev_d;
        idx = 0;
        prev_stall = 1'b0;
        prev_d = '0;
        for (cyc = 0; cyc < 200 && idx < N * N; cyc++) begin
            m_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            clear_lanes();
            if (cyc == inject) begin
                valid_bit_s_in[2] = 1'b1;
                s_in_bus[2]       = 32'd55;
            end
            chk("drain_valid", m_valid, 1);
            if (prev_stall) chk("hold_data", m_data, prev_d);
            chk("m_data", m_data, exp_m[idx / N][idx % N]);
            chk("m_row", m_row, idx / N);
            chk("m_col", m_col, idx % N);
            chk("m_last", m_last, (idx == N * N - 1));
            prev_stall = m_valid && !m_ready;
            prev_d     = m_data;
            if (m_valid && m_ready) idx++;
            tick();
        end
        clear_lanes();
        m_ready = 1'b0;
        chk("handshakes", idx, N * N);
        if (chk_b2b) chk("b2b_cycles", cyc, N * N);
        chk("valid_drop", m_valid, 0);
        chk("busy_idle", busy, 0);
    endtask

    task automatic do_reset();
        clear_lanes();
        m_ready = 1'b0;
        rst_n   = 1'b0;
        #2;
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_data", m_data, 0);
        chk("rst_row", m_row, 0);
        chk("rst_col", m_col, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                exp_m[r][c] = r * N + c + 1;
        clear_lanes();
        m_ready = 1'b0;
        rst_n   = 1'b0;
        tick();
        do_reset();

        // Systolic delivery, consumer always ready.
        send(1'b0, -1);
        drain(0, -1, 1'b1);
        chk("err_clean_1", err_overflow, 0);

        // All lanes pulsing together: DRAIN after three input cycles.
        send(1'b1, -1);
        drain(0, -1, 1'b1);
        chk("err_clean_2", err_overflow, 0);

        // Stalling consumer.
        send(1'b0, -1);
        drain(1, -1, 1'b0);
        chk("err_clean_3", err_overflow, 0);

        // Surplus pulse on lane0 after its only element.
        send(1'b0, 3);
        drain(0, -1, 1'b1);
        chk("err_sticky", err_overflow, 1);

        // Pulse during drain is discarded.
        do_reset();
        send(1'b0, -1);
        drain(0, 2, 1'b1);
        chk("err_drain_pulse", err_overflow, 1);

        // Reset after four captured elements, then a clean matrix.
        for (int t = 0; t < 2; t++) begin
            set_lanes(t, 1'b0);
            tick();
        end
        clear_lanes();
        valid_bit_s_in[0] = 1'b1;
        s_in_bus[0]       = 32'd7;
        tick();
        chk("busy_partial", busy, 1);
        do_reset();
        send(1'b0, -1);
        drain(0, -1, 1'b1);
        chk("err_after_reset", err_overflow, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
